// File: rtl/ov_capture.sv
// ov_capture: captures RGB565 pixels from an OV-style camera bus (vsync, href,
// pclk, 8-bit data) into the clk_sys domain. Every camera pin is oversampled
// through synchronisers, so clk_sys must run at least 4x faster than ov_pclk.
// Two bytes per pixel, first byte high. Per-frame pixel coordinates, frame
// strobes, a completed-frame counter and sticky line/frame error flags.
module ov_capture #(
  parameter int H_PIX   = 640,
  parameter int V_LINES = 480
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        cap_en,
  input  logic        ov_vsync,
  input  logic        ov_href,
  input  logic        ov_pclk,
  input  logic [7:0]  ov_data,
  output logic        pix_vld,
  output logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        frame_start,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        line_err,
  output logic        frame_err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_VS = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;

  localparam logic [9:0] H_LIM = 10'(H_PIX);
  localparam logic [9:0] V_LIM = 10'(V_LINES);
  localparam logic [9:0] Y_MAX = 10'd1023;

  // Synchroniser stages; s2 is the stage all decisions are taken from.
  logic       r_vs_s1, r_vs_s2, r_vs_d;
  logic       r_hr_s1, r_hr_s2, r_hr_d;
  logic       r_pc_s1, r_pc_s2, r_pc_s3;
  logic [7:0] r_dat_s1, r_dat_s2;

  // Capture state.
  logic [1:0]  r_state;
  logic        r_phase;
  logic [7:0]  r_hi_byte;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic        r_inc;
  logic        r_pix_vld;
  logic [15:0] r_pix_data;
  logic        r_frame_start;
  logic        r_frame_done;
  logic [7:0]  r_frame_cnt;
  logic        r_line_err;
  logic        r_frame_err;

  logic       w_sample;
  logic       w_vs_rise;
  logic       w_vs_fall;
  logic       w_hr_fall;
  logic [9:0] w_x_cur;

  // pclk rising edge seen on the synchronised copy; href/data come from the
  // same stage so they are aligned with the edge that qualifies them.
  assign w_sample  = r_pc_s2 & ~r_pc_s3;
  assign w_vs_rise = r_vs_s2 & ~r_vs_d;
  assign w_vs_fall = ~r_vs_s2 & r_vs_d;
  assign w_hr_fall = ~r_hr_s2 & r_hr_d;

  // pix_x is bumped one cycle after the pixel strobe so the strobe cycle
  // still shows the pixel's own column; comparisons must see the bumped value.
  assign w_x_cur = r_inc ? (r_x + 10'd1) : r_x;

  // Synchronise all camera pins and keep one history stage for edge detection.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_vs_s1  <= 1'b0;
      r_vs_s2  <= 1'b0;
      r_vs_d   <= 1'b0;
      r_hr_s1  <= 1'b0;
      r_hr_s2  <= 1'b0;
      r_hr_d   <= 1'b0;
      r_pc_s1  <= 1'b0;
      r_pc_s2  <= 1'b0;
      r_pc_s3  <= 1'b0;
      r_dat_s1 <= 8'd0;
      r_dat_s2 <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's old value; blocking ones would collapse the chain to one flop.
      r_vs_s1  <= ov_vsync;
      r_vs_s2  <= r_vs_s1;
      r_vs_d   <= r_vs_s2;
      r_hr_s1  <= ov_href;
      r_hr_s2  <= r_hr_s1;
      r_hr_d   <= r_hr_s2;
      r_pc_s1  <= ov_pclk;
      r_pc_s2  <= r_pc_s1;
      r_pc_s3  <= r_pc_s2;
      r_dat_s1 <= ov_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Frame/line/pixel state machine, counters and error flags.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_phase       <= 1'b0;
      r_hi_byte     <= 8'd0;
      r_x           <= 10'd0;
      r_y           <= 10'd0;
      r_inc         <= 1'b0;
      r_pix_vld     <= 1'b0;
      r_pix_data    <= 16'd0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_cnt   <= 8'd0;
      r_line_err    <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_pix_vld     <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_inc         <= 1'b0;
      if (r_inc) begin
        r_x <= r_x + 10'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (cap_en) begin
            r_state <= ST_WAIT_VS;
          end
        end

        ST_WAIT_VS: begin
          if (w_vs_fall) begin
            r_state       <= ST_ACTIVE;
            r_frame_start <= 1'b1;
            r_x           <= 10'd0;
            r_y           <= 10'd0;
            r_phase       <= 1'b0;
            r_line_err    <= 1'b0;
            r_frame_err   <= 1'b0;
          end
        end

        ST_ACTIVE: begin
          if (w_vs_rise) begin
            // End of frame; cap_en is only consulted here.
            r_frame_done <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + 8'd1;
            if (r_y != V_LIM) begin
              r_frame_err <= 1'b1;
            end
            r_state <= cap_en ? ST_WAIT_VS : ST_IDLE;
          end else if (w_hr_fall) begin
            // End of line: a short/long line or a dangling odd byte is an error.
            if ((w_x_cur != H_LIM) || r_phase) begin
              r_line_err <= 1'b1;
            end
            r_y     <= (r_y == Y_MAX) ? r_y : (r_y + 10'd1);
            r_x     <= 10'd0;
            r_phase <= 1'b0;
          end else if (w_sample && r_hr_s2) begin
            if (!r_phase) begin
              r_hi_byte <= r_dat_s2;
              r_phase   <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              if (w_x_cur == H_LIM) begin
                // Line overrun: drop the pixel, hold the column.
                r_line_err <= 1'b1;
              end else begin
                r_inc <= 1'b1;
                // Lines past V_LINES are tracked for the line count only.
                if (r_y < V_LIM) begin
                  r_pix_vld  <= 1'b1;
                  r_pix_data <= {r_hi_byte, r_dat_s2};
                end
              end
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pix_vld     = r_pix_vld;
  assign pix_data    = r_pix_data;
  assign pix_x       = r_x;
  assign pix_y       = r_y;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign frame_cnt   = r_frame_cnt;
  assign line_err    = r_line_err;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_ov_capture.sv
// Testbench for ov_capture: drives camera frames built from random bytes and
// compares the captured pixels, strobes, counter and error flags against a
// frame-level reference model (lists of lines and byte counts).
module tb_ov_capture;

  localparam int H = 4;
  localparam int V = 2;

  logic        clk_sys  = 1'b0;
  logic        rst      = 1'b1;
  logic        cap_en   = 1'b0;
  logic        ov_vsync = 1'b0;
  logic        ov_href  = 1'b0;
  logic        ov_pclk  = 1'b0;
  logic [7:0]  ov_data  = 8'd0;
  logic        pix_vld;
  logic [15:0] pix_data;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        frame_start;
  logic        frame_done;
  logic [7:0]  frame_cnt;
  logic        line_err;
  logic        frame_err;

  ov_capture #(.H_PIX(H), .V_LINES(V)) dut (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .cap_en      (cap_en),
    .ov_vsync    (ov_vsync),
    .ov_href     (ov_href),
    .ov_pclk     (ov_pclk),
    .ov_data     (ov_data),
    .pix_vld     (pix_vld),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .line_err    (line_err),
    .frame_err   (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Observed pixels {y, x, data} and strobe counts, sampled mid-cycle.
  logic [35:0] got_q[$];
  logic [35:0] exp_q[$];
  int fs_cnt   = 0;
  int fd_cnt   = 0;
  int both_cnt = 0;

  always @(negedge clk_sys) begin
    if (pix_vld) got_q.push_back({pix_y, pix_x, pix_data});
    if (frame_start) fs_cnt++;
    if (frame_done) fd_cnt++;
    if (frame_start && frame_done) both_cnt++;
  end

  // Reference model state.
  int m_cnt   = 0;
  bit m_lerr  = 1'b0;
  bit m_ferr  = 1'b0;
  bit m_armed = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_byte(input logic [7:0] b);
    ov_data = b;
    step(2);
    ov_pclk = 1'b1;
    step(2);
    ov_pclk = 1'b0;
  endtask

  // One href window of nbytes random bytes; the model expects pixel k of line
  // l only for complete pairs inside the H x V window.
  task automatic drive_line(input int l, input int nbytes, input bit cap);
    logic [7:0] b[$];
    ov_href = 1'b1;
    step(2);
    for (int i = 0; i < nbytes; i++) begin
      b.push_back(8'($urandom));
      send_byte(b[i]);
    end
    step(2);
    ov_href = 1'b0;
    step(4);
    if (cap) begin
      if (l < V)
        for (int k = 0; (k < nbytes / 2) && (k < H); k++)
          exp_q.push_back({10'(l), 10'(k), b[2*k], b[2*k+1]});
      if (nbytes != 2 * H) m_lerr = 1'b1;
    end
  endtask

  task automatic check_frame(input string tag, input bit cap, input int fs0, input int fd0);
    check({tag, "/npix"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "/pix"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
    check({tag, "/fstart"}, 64'(fs_cnt - fs0), 64'(cap));
    check({tag, "/fdone"}, 64'(fd_cnt - fd0), 64'(cap));
    check({tag, "/fcnt"}, 64'(frame_cnt), 64'(m_cnt));
    check({tag, "/lerr"}, 64'(line_err), 64'(m_lerr));
    check({tag, "/ferr"}, 64'(frame_err), 64'(m_ferr));
  endtask

  // Whole frame: vsync high (blanking), fall starts it, lines, rise ends it.
  task automatic drive_frame(input string tag, input int lens[$], input bit drop_en);
    int fs0 = fs_cnt;
    int fd0 = fd_cnt;
    bit cap;
    ov_vsync = 1'b1;
    step(6);
    cap = m_armed || cap_en;
    ov_vsync = 1'b0;
    step(6);
    if (cap) begin
      m_lerr = 1'b0;
      m_ferr = 1'b0;
    end
    if (drop_en) cap_en = 1'b0;
    for (int i = 0; i < lens.size(); i++) drive_line(i, lens[i], cap);
    ov_vsync = 1'b1;
    step(8);
    if (cap) begin
      m_cnt = (m_cnt + 1) % 256;
      if (lens.size() != V) m_ferr = 1'b1;
      m_armed = cap_en;
    end else begin
      m_armed = m_armed || cap_en;
    end
    check_frame(tag, cap, fs0, fd0);
  endtask

  initial begin
    int fs0;
    int fd0;

    // Reset state while rst is held.
    step(3);
    check("rst/vld", 64'(pix_vld), 64'd0);
    check("rst/data", 64'(pix_data), 64'd0);
    check("rst/xy", 64'({pix_x, pix_y}), 64'd0);
    check("rst/strobes", 64'({frame_start, frame_done}), 64'd0);
    check("rst/fcnt", 64'(frame_cnt), 64'd0);
    check("rst/errs", 64'({line_err, frame_err}), 64'd0);
    rst = 1'b0;
    step(4);

    // Frame while disabled is ignored.
    drive_frame("disabled", '{8, 8}, 1'b0);

    cap_en = 1'b1;
    step(2);
    drive_frame("nominal", '{8, 8}, 1'b0);
    drive_frame("short", '{6, 8}, 1'b0);
    drive_frame("odd", '{9, 8}, 1'b0);
    drive_frame("long", '{10, 8}, 1'b0);
    drive_frame("recover", '{8, 8}, 1'b0);
    drive_frame("three_lines", '{8, 8, 8}, 1'b0);
    drive_frame("one_line", '{8}, 1'b0);
    drive_frame("capdrop", '{8, 8}, 1'b1);
    drive_frame("after_drop", '{8, 8}, 1'b0);
    cap_en = 1'b1;
    step(2);
    for (int f = 0; f < 4; f++) drive_frame("random", '{8, 8}, 1'b0);

    // Reset mid-line with href active: partial frame dropped, no frame_done.
    ov_vsync = 1'b1;
    step(6);
    ov_vsync = 1'b0;
    step(6);
    ov_href = 1'b1;
    step(2);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    step(2);
    check("midrst/pre_npix", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) check("midrst/pre_pix", 64'(got_q[0]), 64'({10'd0, 10'd0, 16'hA1B2}));
    got_q.delete();
    fs0 = fs_cnt;
    fd0 = fd_cnt;
    rst = 1'b1;
    step(1);
    check("midrst/vld", 64'(pix_vld), 64'd0);
    check("midrst/fcnt", 64'(frame_cnt), 64'd0);
    check("midrst/xy", 64'({pix_x, pix_y}), 64'd0);
    check("midrst/errs", 64'({line_err, frame_err}), 64'd0);
    rst = 1'b0;
    send_byte(8'hD4);
    send_byte(8'hE5);
    send_byte(8'hF6);
    step(2);
    ov_href = 1'b0;
    step(4);
    ov_vsync = 1'b1;
    step(8);
    check("midrst/post_npix", 64'(got_q.size()), 64'd0);
    check("midrst/fdone", 64'(fd_cnt - fd0), 64'd0);
    check("midrst/fstart", 64'(fs_cnt - fs0), 64'd0);
    got_q.delete();
    m_cnt   = 0;
    m_lerr  = 1'b0;
    m_ferr  = 1'b0;
    m_armed = 1'b1;

    // 256 complete frames: counter wraps back to zero.
    for (int f = 0; f < 256; f++) drive_frame("wrap", '{8, 8}, 1'b0);
    check("wrap/zero", 64'(frame_cnt), 64'd0);
    check("strobe_overlap", 64'(both_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
